// File: rtl/conv_window_formatter_pkg.sv
// Shared types and constants for the convolution window formatter.
// Holds the frame FSM encoding, marker bit positions and kernel margin helper.
package conv_window_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_e;

  localparam int MRK_SOL = 0;
  localparam int MRK_EOL = 1;
  localparam int MRK_SOF = 2;
  localparam int MRK_EOF = 3;
  localparam int MRK_W   = 4;

  // Pixels of context on each side of the window centre.
  function automatic int k_margin(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/conv_window_formatter_raster_counter.sv
// Column/row raster position counter with enable, programmable wrap limits
// and a flag that marks the final position of the frame.
module raster_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] col_last,
  input  logic [15:0] row_last,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        last
);

  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      if (col_q == col_last) begin
        col_d = '0;
        row_d = (row_q == row_last) ? '0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == col_last) && (row_q == row_last);

endmodule

// File: rtl/conv_window_formatter.sv
// Restores frame geometry on the kernel result stream: crops or fills border
// results and tags each output with coordinates and line/frame markers (1 cycle).
module conv_window_formatter
  import conv_window_formatter_pkg::*;
#(
  parameter int           N          = 8,
  parameter int           K          = 3,
  parameter int           FILL_MODE  = 0,
  parameter logic [N-1:0] FILL_VALUE = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [15:0]  width,
  input  logic [15:0]  height,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [15:0]  out_col,
  output logic [15:0]  out_row,
  output logic         out_sol,
  output logic         out_eol,
  output logic         out_sof,
  output logic         out_eof,
  output logic         frame_done,
  output logic         config_error
);

  localparam logic [15:0] BORDER = 16'(2 * k_margin(K));

  logic [15:0] w_q, h_q, w_out_q, h_out_q;
  logic        cfg_err_q;
  fsm_state_e  state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [15:0]      out_col_q, out_col_d;
  logic [15:0]      out_row_q, out_row_d;
  logic [MRK_W-1:0] mrk_q, mrk_d;

  logic [15:0] in_col, in_row;
  logic        in_last;
  logic [15:0] oc_col, oc_row;
  logic        oc_last;
  logic [15:0] out_col_last, out_row_last;
  logic        accept, interior, emit;

  assign accept       = in_valid && !cfg_err_q;
  assign interior     = (in_col >= BORDER) && (in_row >= BORDER);
  assign emit         = accept && ((FILL_MODE != 0) || interior);
  assign out_col_last = (FILL_MODE != 0) ? (w_q - 16'd1) : (w_out_q - 16'd1);
  assign out_row_last = (FILL_MODE != 0) ? (h_q - 16'd1) : (h_out_q - 16'd1);

  raster_counter u_in_pos (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (accept),
    .col_last (w_q - 16'd1),
    .row_last (h_q - 16'd1),
    .col      (in_col),
    .row      (in_row),
    .last     (in_last)
  );

  // Crop mode counts interior beats only, so its position is the output coordinate.
  generate
    if (FILL_MODE == 0) begin : g_crop
      raster_counter u_out_pos (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (accept && interior),
        .col_last (out_col_last),
        .row_last (out_row_last),
        .col      (oc_col),
        .row      (oc_row),
        .last     (oc_last)
      );
    end else begin : g_fill
      assign oc_col  = in_col;
      assign oc_row  = in_row;
      assign oc_last = (in_col == out_col_last) && (in_row == out_row_last);
    end
  endgenerate

  always_comb begin
    out_valid_d = emit;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    mrk_d       = '0;
    if (emit) begin
      out_data_d     = interior ? in_data : FILL_VALUE;
      out_col_d      = oc_col;
      out_row_d      = oc_row;
      mrk_d[MRK_SOL] = (oc_col == 16'd0);
      mrk_d[MRK_EOL] = (oc_col == out_col_last);
      mrk_d[MRK_SOF] = (oc_col == 16'd0) && (oc_row == 16'd0);
      mrk_d[MRK_EOF] = oc_last;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = in_last ? ST_DONE : ST_ACTIVE;
      ST_ACTIVE: if (accept && in_last) state_d = ST_DONE;
      ST_DONE:   state_d = accept ? (in_last ? ST_DONE : ST_ACTIVE) : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Geometry and derived output frame size are captured only while in reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      w_q         <= width;
      h_q         <= height;
      w_out_q     <= width - 16'(K - 1);
      h_out_q     <= height - 16'(K - 1);
      cfg_err_q   <= (width < 16'(K)) || (height < 16'(K));
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      mrk_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      mrk_q       <= mrk_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_col      = out_col_q;
  assign out_row      = out_row_q;
  assign out_sol      = mrk_q[MRK_SOL];
  assign out_eol      = mrk_q[MRK_EOL];
  assign out_sof      = mrk_q[MRK_SOF];
  assign out_eof      = mrk_q[MRK_EOF];
  assign frame_done   = (state_q == ST_DONE);
  assign config_error = cfg_err_q;

endmodule

// File: tb/tb_conv_window_formatter.sv
// Drives a crop and a fill instance with the same stream and checks both
// against a raster-index model every cycle, plus literal frame expectations.
module tb_conv_window_formatter;

  localparam int KK = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] width, height;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        c_out_valid, c_out_sol, c_out_eol, c_out_sof, c_out_eof, c_frame_done, c_config_error;
  logic [7:0]  c_out_data;
  logic [15:0] c_out_col, c_out_row;
  logic        f_out_valid, f_out_sol, f_out_eol, f_out_sof, f_out_eof, f_frame_done, f_config_error;
  logic [7:0]  f_out_data;
  logic [15:0] f_out_col, f_out_row;

  always #5 clock = ~clock;

  conv_window_formatter #(.N(8), .K(KK), .FILL_MODE(0), .FILL_VALUE(8'h00)) u_crop (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_col(c_out_col), .out_row(c_out_row),
    .out_sol(c_out_sol), .out_eol(c_out_eol), .out_sof(c_out_sof), .out_eof(c_out_eof),
    .frame_done(c_frame_done), .config_error(c_config_error)
  );

  conv_window_formatter #(.N(8), .K(KK), .FILL_MODE(1), .FILL_VALUE(8'hFF)) u_fill (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(f_out_valid), .out_data(f_out_data), .out_col(f_out_col), .out_row(f_out_row),
    .out_sol(f_out_sol), .out_eol(f_out_eol), .out_sof(f_out_sof), .out_eof(f_out_eof),
    .frame_done(f_frame_done), .config_error(f_config_error)
  );

  typedef struct packed {
    logic        vld;
    logic [7:0]  dat;
    logic [15:0] col;
    logic [15:0] row;
    logic        sol, eol, sof, eof, done, cerr;
  } obs_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   mw, mh, n;
  bit   mcerr;
  obs_t exp_c, exp_f;

  int       c_vld_cnt, c_done_cnt, f_vld_cnt, f_ff_cnt, f_done_cnt, f_eof_col, f_eof_row, c_eof_dat;
  int       c_q[$];
  int       sof_q[$];
  int       eol_q[$];

  function automatic obs_t emit_model(bit fill, obs_t prev, bit acc, int c, int r,
                                      logic [7:0] d, bit done);
    obs_t o;
    int   ocol, orow, lc, lr;
    bit   inner;
    o = prev;
    o.vld = 0; o.sol = 0; o.eol = 0; o.sof = 0; o.eof = 0;
    o.done = done;
    if (!acc) return o;
    inner = (c >= KK - 1) && (r >= KK - 1);
    if (!fill) begin
      if (!inner) return o;
      ocol = c - (KK - 1); orow = r - (KK - 1);
      lc = mw - KK; lr = mh - KK;
      o.dat = d;
    end else begin
      ocol = c; orow = r; lc = mw - 1; lr = mh - 1;
      o.dat = inner ? d : 8'hFF;
    end
    o.vld = 1;
    o.col = 16'(ocol);
    o.row = 16'(orow);
    o.sol = (ocol == 0);
    o.eol = (ocol == lc);
    o.sof = (ocol == 0) && (orow == 0);
    o.eof = (ocol == lc) && (orow == lr);
    return o;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] d);
    bit acc, done;
    int c, r;
    if (!reset_n) begin
      mw = int'(width); mh = int'(height);
      mcerr = (mw < KK) || (mh < KK);
      n = 0;
      exp_c = '0; exp_f = '0;
      exp_c.cerr = mcerr; exp_f.cerr = mcerr;
      return;
    end
    acc = v && !mcerr;
    c = 0; r = 0; done = 0;
    if (acc) begin
      c = n % mw;
      r = n / mw;
      done = (n == mw * mh - 1);
    end
    exp_c = emit_model(0, exp_c, acc, c, r, d, done);
    exp_f = emit_model(1, exp_f, acc, c, r, d, done);
    if (acc) n = done ? 0 : n + 1;
  endtask

  task automatic check();
    obs_t act_c, act_f;
    act_c = {c_out_valid, c_out_data, c_out_col, c_out_row, c_out_sol, c_out_eol,
             c_out_sof, c_out_eof, c_frame_done, c_config_error};
    act_f = {f_out_valid, f_out_data, f_out_col, f_out_row, f_out_sol, f_out_eol,
             f_out_sof, f_out_eof, f_frame_done, f_config_error};
    vectors++;
    if (act_c !== exp_c) begin
      miscompares++;
      $display("FAIL crop_outputs t=%0t got=%h want=%h", $time, act_c, exp_c);
    end
    vectors++;
    if (act_f !== exp_f) begin
      miscompares++;
      $display("FAIL fill_outputs t=%0t got=%h want=%h", $time, act_f, exp_f);
    end
    if (c_out_valid === 1'b1) begin
      c_vld_cnt++;
      c_q.push_back(int'(c_out_data));
      if (c_out_sof) sof_q.push_back(int'(c_out_data));
      if (c_out_eol) eol_q.push_back(int'(c_out_data));
      if (c_out_eof) c_eof_dat = int'(c_out_data);
    end
    if (c_frame_done === 1'b1) c_done_cnt++;
    if (f_out_valid === 1'b1) begin
      f_vld_cnt++;
      if (f_out_data == 8'hFF) f_ff_cnt++;
      if (f_out_eof) begin f_eof_col = int'(f_out_col); f_eof_row = int'(f_out_row); end
    end
    if (f_frame_done === 1'b1) f_done_cnt++;
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    model_step(v, d);
    @(negedge clock);
    check();
  endtask

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_stats();
    c_vld_cnt = 0; c_done_cnt = 0; f_vld_cnt = 0; f_ff_cnt = 0; f_done_cnt = 0;
    f_eof_col = -1; f_eof_row = -1; c_eof_dat = -1;
    c_q.delete(); sof_q.delete(); eol_q.delete();
  endtask

  task automatic do_reset(input int w, input int h);
    reset_n = 1'b0;
    width   = 16'(w);
    height  = 16'(h);
    step(0, 8'h00);
    step(0, 8'h00);
    reset_n = 1'b1;
  endtask

  task automatic run_frame(input int beats, input bit alt);
    for (int i = 0; i < beats; i++) begin
      step(1, 8'(i));
      if (alt) step(0, 8'hAA);
    end
    step(0, 8'h00);
    step(0, 8'h00);
  endtask

  task automatic check_crop_list(input string tag);
    int lit [6];
    lit = '{12, 13, 14, 17, 18, 19};
    chk({tag, "_crop_count"}, c_q.size(), 6);
    for (int i = 0; i < 6; i++) chk({tag, "_crop_index"}, qat(c_q, i), lit[i]);
    chk({tag, "_crop_done_count"}, c_done_cnt, 1);
  endtask

  initial begin
    reset_n  = 1'b0;
    width    = 16'd5;
    height   = 16'd4;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_stats();

    do_reset(5, 4);
    chk("reset_out_valid", int'(c_out_valid), 0);
    chk("reset_config_error", int'(c_config_error), 0);

    clear_stats();
    run_frame(20, 0);
    check_crop_list("contig");
    chk("crop_sof_index", qat(sof_q, 0), 12);
    chk("crop_eol_first", qat(eol_q, 0), 14);
    chk("crop_eol_second", qat(eol_q, 1), 19);
    chk("crop_eof_index", c_eof_dat, 19);
    chk("fill_count", f_vld_cnt, 20);
    chk("fill_ff_count", f_ff_cnt, 14);
    chk("fill_eof_col", f_eof_col, 4);
    chk("fill_eof_row", f_eof_row, 3);
    chk("fill_done_count", f_done_cnt, 1);

    clear_stats();
    run_frame(20, 1);
    check_crop_list("alternate");

    clear_stats();
    run_frame(40, 0);
    chk("b2b_done_count", c_done_cnt, 2);
    chk("b2b_sof_first", qat(sof_q, 0), 12);
    chk("b2b_sof_second", qat(sof_q, 1), 32);
    chk("b2b_crop_count", c_vld_cnt, 12);

    clear_stats();
    for (int i = 0; i < 9; i++) step(1, 8'(i));
    do_reset(6, 3);
    run_frame(18, 0);
    chk("abort_crop_count", c_vld_cnt, 4);
    chk("abort_done_count", c_done_cnt, 1);

    do_reset(2, 8);
    clear_stats();
    for (int i = 0; i < 16; i++) step(1, 8'(i));
    step(0, 8'h00);
    chk("cfgerr_flag", int'(c_config_error), 1);
    chk("cfgerr_crop_valid", c_vld_cnt, 0);
    chk("cfgerr_fill_valid", f_vld_cnt, 0);
    chk("cfgerr_done", c_done_cnt + f_done_cnt, 0);

    for (int it = 0; it < 30; it++) begin
      int w, h, beats, pct;
      w     = $urandom_range(1, 9);
      h     = $urandom_range(1, 7);
      beats = $urandom_range(0, 2 * w * h + 5);
      pct   = $urandom_range(40, 100);
      do_reset(w, h);
      for (int b = 0; b < beats; b++) begin
        if ($urandom_range(1, 100) <= pct) step(1, 8'($urandom_range(0, 255)));
        else step(0, 8'($urandom_range(0, 255)));
      end
    end
    step(0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window_formatter.md
Name: conv_window_formatter

Overview:
- Sits downstream of the K×K window line-buffer and kernel arithmetic.
- The line buffer emits one window per pixel read, including windows that straddle the row wrap or the top border.
- This block restores frame geometry on that result stream: it tracks column and row, then either crops invalid border results or replaces them with a fill value.
- It tags every output with coordinates and line/frame markers for the downstream image writer.

Parameters:
- N, 8, result data width in bits.
- K, 3, kernel size (odd, 3 or 5); sets the border margin K-1.
- FILL_MODE, 0, 0 = crop (emit interior only), 1 = fill (emit every position; border replaced).
- FILL_VALUE, 0, N-bit value substituted for border results in fill mode.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset; geometry is latched while low.
- width  in  16  frame width in pixels; sampled while reset_n=0.
- height  in  16  frame height in pixels; sampled while reset_n=0.
- in_valid  in  1  kernel result valid (one per input pixel, raster order).
- in_data  in  N  kernel result.
- out_valid  out  1  output pixel valid.
- out_data  out  N  output pixel.
- out_col  out  16  output column.
- out_row  out  16  output row.
- out_sol  out  1  first pixel of an output line.
- out_eol  out  1  last pixel of an output line.
- out_sof  out  1  first pixel of the frame.
- out_eof  out  1  last pixel of the frame.
- frame_done  out  1  one-cycle pulse after the last input of a frame.
- config_error  out  1  latched geometry is unusable.

Behaviour:
- Reset and configuration
  - Reset is synchronous, active-low on reset_n; clock is clock.
  - While reset_n=0: W<=width, H<=height. All outputs, counters and FSM are cleared to 0/IDLE.
  - config_error <= (width<K) | (height<K) during reset; it holds until the next reset.
  - While config_error=1, in_valid is ignored and out_valid stays 0.
- Input counters
  - col_in/row_in count accepted in_valid beats only; gaps in in_valid freeze all state.
  - At col_in=W-1: col_in<=0, row_in<=row_in+1.
  - At (W-1,H-1): both counters <=0, frame_done pulses next cycle.
- Border rule
  - Input beat (c,r) is interior iff c>=K-1 and r>=K-1.
  - Margin M=(K-1)/2.
- Crop mode
  - Emit only interior beats.
  - out_col=c-(K-1), out_row=r-(K-1), giving an output frame of (W-K+1)×(H-K+1).
  - out_data=in_data.
- Fill mode
  - Emit every beat with out_col=c, out_row=r.
  - out_data = interior ? in_data : FILL_VALUE.
- Markers are evaluated on output coordinates and output frame size:
  - out_sol: out_col=0.
  - out_eol: out_col=last.
  - out_sof: both coordinates 0.
  - out_eof: both coordinates last.
- Timing
  - Latency is 1 cycle, in_valid→out_valid, with all outputs registered.
  - Full throughput: one result per clock.
  - out_valid=0 on every cycle without an emitted beat.
  - Non-valid cycles hold out_data/out_col/out_row; markers drop to 0.
- FSM
  - IDLE → ACTIVE on the first accepted beat.
  - ACTIVE → DONE on the beat at (W-1,H-1).
  - DONE asserts frame_done for one cycle, then → IDLE.
  - An in_valid arriving in DONE is accepted as beat (0,0) of the next frame; the FSM goes DONE→ACTIVE and frame_done still pulses.
- Reset mid-frame discards partial state; no frame_done is issued.
- Arithmetic uses 16-bit unsigned values; W-K+1 is computed once at reset into a register.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ACTIVE/DONE).
  - Marker bit positions.
  - A K-to-margin constant function.
- One sub-module, raster_counter: a 16-bit col/row counter with enable, wrap at W-1/H-1, and last-pixel flag.
- The block uses one raster_counter for the input position.
- A second raster_counter, for output coordinates, is used in crop mode only.

Test Plan:
- Crop, K=3, W=5, H=4, 20 contiguous beats with in_data=index:
  - Exactly 6 outputs, at input indices 12,13,14,17,18,19.
  - Coordinates (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - out_sof on index 12, out_eol on 14 and 19, out_eof on 19.
  - frame_done one cycle after the 20th beat.
- Fill, K=3, FILL_VALUE=0xFF, W=5, H=4:
  - 20 outputs.
  - Indices 0–11, 15, 16 carry 0xFF; the others carry their index.
  - out_eof at (4,3).
- Same crop frame with in_valid on alternate cycles → identical output sequence, each output 1 cycle after its input, frame_done once.
- Back-to-back frames with no gap (40 beats) → two frame_done pulses; second frame out_sof at input beat 32 (row 2 col 2 of frame 2).
- Reset asserted after 9 beats, width=6 height=3 applied, full frame replayed → crop emits 4 outputs, no frame_done from the aborted frame.
- Reset with width=2, height=8 → config_error=1; 16 beats produce no out_valid and no frame_done.
